// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl
//   Read-side controller for the asynchronous FIFO. It issues pops into the
//   FIFO read port and absorbs the FIFO's one-cycle read latency in a
//   two-entry output buffer. The buffered words are presented downstream as a
//   valid/ready stream. It also provides a flush sequence, which drains the
//   FIFO and discards the words, and a counter of delivered words.
//   All logic runs in the FIFO read clock domain.
//
// Parameters
//   DATA_WIDTH     width of FIFO words and m_data
//   CNT_WIDTH      width of words_cnt (the counter wraps)
//
// Ports
//   rdclk          read-domain clock; all state updates on the rising edge
//   rd_rst_n       asynchronous active-low reset
//   enable         1 = fetch words from the FIFO
//   flush          one-cycle pulse: discard the buffer and drain the FIFO
//   fifo_empty     FIFO empty flag (read domain)
//   fifo_data_out  FIFO read data, valid one cycle after fifo_pop
//   fifo_pop       pop request to the FIFO (combinational)
//   m_valid        an output word is available
//   m_ready        downstream accepts the word
//   m_data         head word of the output buffer
//   busy           controller is not idle
//   flush_done     one-cycle pulse in the cycle a flush completes
//   words_cnt      number of words delivered (m_valid & m_ready)

module fifo_pop_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rdclk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_pop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  words_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;

  // Buffer occupancy (0..2) and the "pop issued last cycle" flag. By the pop
  // rule, occ + inflight never exceeds 2 after any clock edge, so a word
  // arriving from the FIFO always has a free slot.
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic                  inflight;

  // Two-entry buffer: head_word is what m_data shows, tail_word sits behind.
  logic [DATA_WIDTH-1:0] head_word;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] tail_word;
  logic [DATA_WIDTH-1:0] tail_next;

  logic                  xfer;
  logic                  capture;
  logic                  drain_entry;
  logic                  room;

  assign m_valid = (occ != 2'd0);
  assign m_data  = head_word;
  assign busy    = (state != IDLE);
  assign xfer    = m_valid & m_ready;

  // A pop may be issued when the word it returns is guaranteed a slot: either
  // there is room counting the word still in flight, or the head leaves the
  // buffer this same cycle.
  assign room    = ((occ + {1'b0, inflight}) < 2'd2) | xfer;

  // Words returned while draining are thrown away instead of buffered.
  assign capture     = inflight & (state != DRAIN);
  assign drain_entry = (state != DRAIN) & (state_next == DRAIN);

  // Next-state, pop request and flush completion.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    flush_done = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          state_next = DRAIN;
        end else if (enable) begin
          state_next = RUN;
        end
      end
      RUN: begin
        fifo_pop = enable & ~fifo_empty & room;
        if (flush) begin
          state_next = DRAIN;
        end else if (!enable && !inflight) begin
          // Stay in RUN while a popped word is still on its way so it is
          // captured; already-buffered words remain deliverable in IDLE.
          state_next = IDLE;
        end
      end
      DRAIN: begin
        // A further flush pulse here is ignored, as is enable.
        fifo_pop = ~fifo_empty;
        if (fifo_empty && !inflight) begin
          state_next = IDLE;
          flush_done = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Buffer update. A simultaneous capture and transfer keeps occ unchanged
  // and preserves order: the new word always lands behind the current one.
  always_comb begin
    occ_next  = occ;
    head_next = head_word;
    tail_next = tail_word;
    if (drain_entry) begin
      // Entering DRAIN discards everything buffered; payload regs keep their
      // contents so m_data does not toggle needlessly.
      occ_next = 2'd0;
    end else begin
      case ({capture, xfer})
        2'b01: begin
          head_next = tail_word;
          occ_next  = occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            head_next = fifo_data_out;
          end else begin
            tail_next = fifo_data_out;
          end
          occ_next = occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_next = fifo_data_out;
          end else begin
            head_next = tail_word;
            tail_next = fifo_data_out;
          end
        end
        default: begin
          occ_next = occ;
        end
      endcase
    end
  end

  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state     <= IDLE;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      head_word <= '0;
      tail_word <= '0;
      words_cnt <= '0;
    end else begin
      state     <= state_next;
      occ       <= occ_next;
      inflight  <= fifo_pop;
      head_word <= head_next;
      tail_word <= tail_next;
      if (xfer) begin
        words_cnt <= words_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl
//   Self-checking bench for fifo_pop_ctrl. A queue stands in for the FIFO
//   (one-cycle read latency), a second queue holds the words the downstream
//   side must receive in order, and counters track pops, deliveries and the
//   expected words_cnt (4-bit here so wrap-around is reachable quickly).

module tb_fifo_pop_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          flush;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_pop;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          busy;
  logic          flush_done;
  logic [CW-1:0] words_cnt;

  always #5 clk = ~clk;

  fifo_pop_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rdclk        (clk),
    .rd_rst_n     (rst_n),
    .enable       (enable),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_pop     (fifo_pop),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .busy         (busy),
    .flush_done   (flush_done),
    .words_cnt    (words_cnt)
  );

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            popped = 0;
  int            delivered = 0;
  logic [CW-1:0] cnt_model = '0;
  int            pops_seen = 0;
  int            xfers_seen = 0;
  int            done_seen = 0;
  int            first_xfer = -1;
  int            last_xfer = -1;
  int            cyc = 0;
  bit            flushing = 1'b0;
  bit            hold_pending = 1'b0;
  logic [DW-1:0] hold_data = '0;

  // Put a word into the FIFO; keep=1 means downstream must eventually see it.
  task automatic push(input logic [DW-1:0] w, input bit keep);
    fifo_q.push_back(w);
    if (keep) exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic tick();
    logic          p;
    logic          x;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    #1;
    p = fifo_pop;
    x = m_valid & m_ready;
    d = m_data;
    checks++;
    if (p === 1'b1 && fifo_empty) begin
      errors++;
      $display("FAIL underflow: fifo_pop=%b while fifo_empty=1 (cycle %0d)", p, cyc);
    end
    checks++;
    if (words_cnt !== cnt_model) begin
      errors++;
      $display("FAIL words_cnt: got %0d expected %0d (cycle %0d)", words_cnt, cnt_model, cyc);
    end
    if (hold_pending && m_valid === 1'b1) begin
      checks++;
      if (d !== hold_data) begin
        errors++;
        $display("FAIL hold: m_data changed to %h while stalled, expected %h (cycle %0d)", d, hold_data, cyc);
      end
    end
    if (x === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_word: unexpected transfer of %h (cycle %0d)", d, cyc);
      end else begin
        e = exp_q.pop_front();
        if (d !== e) begin
          errors++;
          $display("FAIL data: got %h expected %h (cycle %0d)", d, e, cyc);
        end
      end
      delivered++;
      cnt_model = cnt_model + 1'b1;
      xfers_seen++;
      last_xfer = cyc;
      if (first_xfer < 0) first_xfer = cyc;
    end
    if (p === 1'b1) begin
      popped++;
      pops_seen++;
    end
    if (flush_done === 1'b1) done_seen++;
    if (!flushing) begin
      checks++;
      if (popped - delivered > 2) begin
        errors++;
        $display("FAIL occupancy: %0d words held, expected at most 2 (cycle %0d)", popped - delivered, cyc);
      end
    end
    hold_pending = (m_valid === 1'b1) && (m_ready === 1'b0);
    hold_data = d;
    @(posedge clk);
    #1;
    if (p === 1'b1) begin
      if (fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_data_out = '0;
    #2;
    checks++;
    if ({fifo_pop, m_valid, busy, flush_done, m_data, words_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: pop=%b valid=%b busy=%b done=%b data=%h cnt=%0d required all 0",
               fifo_pop, m_valid, busy, flush_done, m_data, words_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset: %0d errors so far", errors);
  endtask

  task automatic test_stream();
    enable = 1'b1; m_ready = 1'b1;
    xfers_seen = 0; first_xfer = -1; last_xfer = -1;
    for (int i = 0; i <= 10; i++) push(DW'(i), 1'b1);
    run(20);
    checks++;
    if (xfers_seen != 11 || last_xfer - first_xfer != 10) begin
      errors++;
      $display("FAIL stream_rate: %0d words over %0d cycles, required 11 over 11",
               xfers_seen, last_xfer - first_xfer + 1);
    end
    checks++;
    if (words_cnt !== 4'd11 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: words_cnt=%0d m_valid=%b, required 11 and 0", words_cnt, m_valid);
    end
    $display("test_stream: %0d words, %0d errors so far", xfers_seen, errors);
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0; pops_seen = 0;
    for (int i = 0; i < 5; i++) push(DW'(i), 1'b1);
    run(10);
    checks++;
    if (pops_seen != 2) begin
      errors++;
      $display("FAIL stall_pops: got %0d pops, expected 2", pops_seen);
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL stall_head: m_valid=%b m_data=%h, expected 1 and 00", m_valid, m_data);
    end
    m_ready = 1'b1; xfers_seen = 0;
    run(15);
    checks++;
    if (xfers_seen != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_release: %0d words delivered, expected 5", xfers_seen);
    end
    $display("test_backpressure: %0d errors so far", errors);
  endtask

  task automatic test_underflow();
    m_ready = 1'b1; xfers_seen = 0;
    for (int i = 0; i < 3; i++) push(DW'($urandom_range(255)), 1'b1);
    run(12);
    checks++;
    if (xfers_seen != 3 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL underflow_end: %0d transfers m_valid=%b, expected 3 and 0", xfers_seen, m_valid);
    end
    $display("test_underflow: %0d errors so far", errors);
  endtask

  task automatic test_flush();
    logic [CW-1:0] cnt_before;
    flushing = 1'b1; m_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 2; i++) push(DW'($urandom_range(255)), 1'b0);
    run(5);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: m_valid=%b, expected 1", m_valid);
    end
    for (int i = 0; i < 6; i++) push(DW'($urandom_range(255)), 1'b0);
    cnt_before = words_cnt;
    pops_seen = 0; done_seen = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0; enable = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_enter: m_valid=%b busy=%b, expected 0 and 1", m_valid, busy);
    end
    tick();
    flush = 1'b1;
    enable = 1'b1;
    tick();
    flush = 1'b0;
    enable = 1'b0;
    run(12);
    checks++;
    if (pops_seen != 6 || done_seen != 1) begin
      errors++;
      $display("FAIL flush_drain: pops=%0d done_pulses=%0d, expected 6 and 1", pops_seen, done_seen);
    end
    checks++;
    if (words_cnt !== cnt_before || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_end: words_cnt=%0d busy=%b m_valid=%b, expected %0d 0 0",
               words_cnt, busy, m_valid, cnt_before);
    end
    popped = delivered;
    flushing = 1'b0;
    $display("test_flush: %0d errors so far", errors);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      enable = ($urandom_range(99) < 80);
      m_ready = $urandom_range(1);
      if ($urandom_range(99) < 40) push(DW'($urandom_range(255)), 1'b1);
      tick();
    end
    enable = 1'b1; m_ready = 1'b1;
    run(60);
    checks++;
    if (exp_q.size() != 0 || fifo_q.size() != 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: %0d words undelivered, fifo holds %0d, m_valid=%b, expected 0 0 0",
               exp_q.size(), fifo_q.size(), m_valid);
    end
    $display("test_random: %0d words delivered in total, %0d errors so far", delivered, errors);
  endtask

  task automatic test_reset_midstream();
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(8'hA0 + i), 1'b1);
    run(2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_pop, m_valid, busy, flush_done, m_data, words_cnt} !== '0) begin
      errors++;
      $display("FAIL midstream_reset: pop=%b valid=%b busy=%b done=%b data=%h cnt=%0d required all 0",
               fifo_pop, m_valid, busy, flush_done, m_data, words_cnt);
    end
    fifo_q.delete(); exp_q.delete();
    fifo_empty = 1'b1; fifo_data_out = '0;
    cnt_model = '0; popped = 0; delivered = 0; hold_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    run(3);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midstream_clear: m_valid=%b after reset, expected 0", m_valid);
    end
    $display("test_reset_midstream: %0d errors so far", errors);
  endtask

  task automatic test_wrap();
    enable = 1'b1; m_ready = 1'b1; xfers_seen = 0;
    for (int i = 0; i < 17; i++) push(DW'($urandom_range(255)), 1'b1);
    run(30);
    checks++;
    if (xfers_seen != 17 || words_cnt !== 4'd1) begin
      errors++;
      $display("FAIL wrap: %0d transfers words_cnt=%0d, expected 17 and 1", xfers_seen, words_cnt);
    end
    $display("test_wrap: %0d errors so far", errors);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_underflow();
    test_flush();
    test_random();
    test_reset_midstream();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
